// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: word width, the PC
// increment, the fetch FSM encoding and a word-alignment helper.
package fetch_unit_pkg;

    localparam int WORD_WIDTH        = 32;
    localparam int FETCH_STATE_WIDTH = 2;

    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    localparam logic [WORD_WIDTH-1:0] PC_STEP   = 32'd4;

    // FETCH   : request outstanding (or about to be) for pc
    // HOLD    : instruction captured, parked behind a stall, no request
    // DISCARD : stale request in flight after a redirect, data will be dropped
    typedef enum logic [FETCH_STATE_WIDTH-1:0] {
        FETCH_S_FETCH   = 2'd0,
        FETCH_S_HOLD    = 2'd1,
        FETCH_S_DISCARD = 2'd2
    } fetch_state_e;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
        return addr & ~(WORD_WIDTH'(3));
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the single-outstanding
// instruction-memory handshake, and presents instrF/pcF to if_id.
// A redirect that arrives while a request is in flight must wait for the
// stale ack, because the request cannot be withdrawn once raised.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallF,
    input  logic                  redirect_valid,
    input  logic [WORD_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] instrF,
    output logic [WORD_WIDTH-1:0] pcF,
    output logic                  fetch_busy
);

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] pc_next;
    logic [WORD_WIDTH-1:0] instr_buf;
    logic [WORD_WIDTH-1:0] instr_buf_next;
    logic [WORD_WIDTH-1:0] pending_pc;
    logic [WORD_WIDTH-1:0] pending_pc_next;
    logic [WORD_WIDTH-1:0] redirect_target;
    logic [WORD_WIDTH-1:0] pc_inc;

    assign redirect_target = word_align(redirect_pc);
    assign pc_inc          = pc + PC_STEP;

    // State and datapath registers, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH_S_FETCH;
            pc         <= RESET_PC;
            instr_buf  <= ZERO_WORD;
            pending_pc <= ZERO_WORD;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr_buf  <= instr_buf_next;
            pending_pc <= pending_pc_next;
        end
    end

    // Next-state and next-PC selection; redirects outrank stalls everywhere.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instr_buf_next  = instr_buf;
        pending_pc_next = pending_pc;

        case (state)
            FETCH_S_FETCH: begin
                if (redirect_valid && imem_ack) begin
                    pc_next = redirect_target;
                end else if (redirect_valid) begin
                    pending_pc_next = redirect_target;
                    state_next      = FETCH_S_DISCARD;
                end else if (imem_ack && stallF) begin
                    instr_buf_next = imem_rdata;
                    state_next     = FETCH_S_HOLD;
                end else if (imem_ack) begin
                    pc_next = pc_inc;
                end
            end

            FETCH_S_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = FETCH_S_FETCH;
                end else if (!stallF) begin
                    pc_next    = pc_inc;
                    state_next = FETCH_S_FETCH;
                end
            end

            FETCH_S_DISCARD: begin
                if (redirect_valid && imem_ack) begin
                    pc_next    = redirect_target;
                    state_next = FETCH_S_FETCH;
                end else if (redirect_valid) begin
                    pending_pc_next = redirect_target;
                end else if (imem_ack) begin
                    pc_next    = pending_pc;
                    state_next = FETCH_S_FETCH;
                end
            end

            default: begin
                state_next = FETCH_S_FETCH;
            end
        endcase
    end

    // Output multiplexing; while reset is held no request goes out and the
    // stage reports itself busy so the decode stage sees bubbles.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = pc;
        instrF     = imem_rdata;
        pcF        = pc;
        fetch_busy = 1'b1;

        if (rst) begin
            case (state)
                FETCH_S_FETCH: begin
                    imem_req   = 1'b1;
                    fetch_busy = !imem_ack;
                end
                FETCH_S_HOLD: begin
                    imem_req   = 1'b0;
                    instrF     = instr_buf;
                    fetch_busy = 1'b0;
                end
                FETCH_S_DISCARD: begin
                    imem_req   = 1'b1;
                    fetch_busy = 1'b1;
                end
                default: begin
                    imem_req   = 1'b0;
                    fetch_busy = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model with programmable ack latency, a queue
// of expected request addresses popped on every completed handshake, and
// direct checks of busy/stall/redirect behaviour.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stallF;
    logic                  redirect_valid;
    logic [WORD_WIDTH-1:0] redirect_pc;
    logic                  imem_req;
    logic [WORD_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [WORD_WIDTH-1:0] imem_rdata;
    logic [WORD_WIDTH-1:0] instrF;
    logic [WORD_WIDTH-1:0] pcF;
    logic                  fetch_busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int mem_latency  = 0;
    int waited       = 0;
    logic                  prev_pending = 1'b0;
    logic [WORD_WIDTH-1:0] prev_addr    = '0;
    logic [WORD_WIDTH-1:0] exp_q[$];

    fetch_unit #(
        .RESET_PC(32'h0000_3000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallF         (stallF),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instrF         (instrF),
        .pcF            (pcF),
        .fetch_busy     (fetch_busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory contents: a distinct word derived from every address.
    function automatic logic [WORD_WIDTH-1:0] instr_of(input logic [WORD_WIDTH-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs after the edge, let the memory model
    // answer the request, then score the handshake and delivered instruction.
    task automatic applyStimulus(input logic rst_v, input logic stall_v,
                                 input logic redir_v, input logic [31:0] rpc_v);
        logic [31:0] exp_addr;
        @(posedge clk);
        #1;
        rst            = rst_v;
        stallF         = stall_v;
        redirect_valid = redir_v;
        redirect_pc    = rpc_v;
        #1;
        if (imem_req && (waited >= mem_latency)) begin
            imem_ack   = 1'b1;
            imem_rdata = instr_of(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        #1;
        if (rst_v && prev_pending) begin
            checkOutput("req_hold", 32'(imem_req), 32'd1);
            checkOutput("addr_hold", imem_addr, prev_addr);
        end
        if (imem_req && imem_ack) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_addr = exp_q.pop_front();
                checkOutput("req_addr", imem_addr, exp_addr);
            end
        end
        if (!fetch_busy) checkOutput("instrF", instrF, instr_of(pcF));
        if (imem_req && imem_ack) waited = 0;
        else if (imem_req)        waited++;
        else                      waited = 0;
        prev_pending = imem_req && !imem_ack;
        prev_addr    = imem_addr;
    endtask

    // Two cycles of reset with zero-wait memory.
    task automatic doReset();
        exp_q.delete();
        mem_latency = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_busy", 32'(fetch_busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_pcF", pcF, 32'h0000_3000);
        checkOutput("rst_req2", 32'(imem_req), 32'd0);
    endtask

    initial begin
        rst            = 1'b0;
        stallF         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;

        // Zero-wait streaming from the reset PC.
        doReset();
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        exp_q.push_back(32'h3008);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("stream_busy", 32'(fetch_busy), 32'd0);
        end

        // Three wait states; stall during the wait must be ignored.
        doReset();
        mem_latency = 3;
        exp_q.push_back(32'h3000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("wait_busy", 32'(fetch_busy), 32'd1);
            checkOutput("wait_addr", imem_addr, 32'h3000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wait_done_busy", 32'(fetch_busy), 32'd0);

        // Stall raised in the ack cycle of 3004 and held.
        mem_latency = 0;
        exp_q.push_back(32'h3004);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_pcF0", pcF, 32'h3004);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("hold_req", 32'(imem_req), 32'd0);
        checkOutput("hold_pcF", pcF, 32'h3004);
        checkOutput("hold_instr", instrF, instr_of(32'h3004));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("release_req", 32'(imem_req), 32'd0);
        checkOutput("release_pcF", pcF, 32'h3004);

        // Redirect to 4000 while 3008 is pending for two cycles.
        mem_latency = 2;
        exp_q.push_back(32'h3008);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h4000);
        checkOutput("after_stall_addr", imem_addr, 32'h3008);
        checkOutput("disc_busy0", 32'(fetch_busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("disc_busy1", 32'(fetch_busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("disc_busy2", 32'(fetch_busy), 32'd1);
        mem_latency = 0;
        exp_q.push_back(32'h4000);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_addr", imem_addr, 32'h4000);

        // Several redirects while discarding: the latest one wins.
        mem_latency = 3;
        exp_q.push_back(32'h4004);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h4800);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h5000);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h6000);
        checkOutput("multi_busy", 32'(fetch_busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("multi_ack_busy", 32'(fetch_busy), 32'd1);
        mem_latency = 0;
        exp_q.push_back(32'h6000);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("latest_addr", imem_addr, 32'h6000);

        // Redirect with ack in the same cycle, PC wrap, unaligned target.
        exp_q.push_back(32'h6004);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(32'h0000_0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_7002);
        checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
        exp_q.push_back(32'h7000);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("align_pcF", pcF, 32'h7000);

        // Redirect out of HOLD beats the stall.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000);
        checkOutput("hold_redir_req", 32'(imem_req), 32'd0);
        exp_q.push_back(32'h8000);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("hold_redir_addr", imem_addr, 32'h8000);

        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. Owns the program counter and drives the instruction-memory request/acknowledge handshake, and presents `instrF`/`pcF` to the `if_id` pipeline register. Honours the fetch stall from the hazard unit and redirects from branch/jump resolution. Reports `fetch_busy` while an instruction-memory access is outstanding so the hazard unit can insert bubbles.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; low two bits must be 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `stallF` input 1: hold the currently presented instruction and PC.
- `redirect_valid` input 1: branch/jump taken; has priority over `stallF`.
- `redirect_pc` input `WORD_WIDTH`: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req` output 1: request to instruction memory.
- `imem_addr` output `WORD_WIDTH`: request address, word aligned.
- `imem_ack` input 1: request accepted; `imem_rdata` is valid in this same cycle.
- `imem_rdata` input `WORD_WIDTH`: fetched instruction word.
- `instrF` output `WORD_WIDTH`: instruction presented to `if_id`.
- `pcF` output `WORD_WIDTH`: PC of `instrF`.
- `fetch_busy` output 1: `instrF` is not valid this cycle. The hazard unit asserts `flushD` whenever `fetch_busy`=1 and `stallD`=0.

## Operation
- Registers:
  - `pc`, reset value `RESET_PC`.
  - `state`, reset value FETCH.
  - `instr_buf`, reset value `ZERO_WORD`.
  - `pending_pc`, reset value `ZERO_WORD`.
- Handshake rules:
  - At most one request is outstanding.
  - Once raised, `imem_req` stays high with `imem_addr` stable until `imem_ack`.
  - `imem_ack` may arrive in the same cycle the request is raised (zero wait states).
- FETCH state:
  - Outputs: `imem_req`=1, `imem_addr`=`pc`, `instrF`=`imem_rdata`, `pcF`=`pc`, `fetch_busy`=`!imem_ack`.
  - Transitions, highest priority first:
    - `redirect_valid` & `imem_ack`: `pc`←`redirect_pc`; stay in FETCH. The returned data is dropped.
    - `redirect_valid` & `!imem_ack`: `pending_pc`←`redirect_pc`; go to DISCARD.
    - `imem_ack` & `stallF`: `instr_buf`←`imem_rdata`; go to HOLD.
    - `imem_ack` & `!stallF`: `pc`←`pc`+4; stay in FETCH.
    - Otherwise: stay in FETCH.
- HOLD state:
  - Outputs: `imem_req`=0, `instrF`=`instr_buf`, `pcF`=`pc`, `fetch_busy`=0.
  - Transitions:
    - `redirect_valid`: `pc`←`redirect_pc`; go to FETCH.
    - `!stallF`: `pc`←`pc`+4; go to FETCH.
    - Otherwise: stay in HOLD.
- DISCARD state:
  - Outputs: `imem_req`=1, `imem_addr`=`pc` (stale request held until acknowledged), `fetch_busy`=1.
  - Transitions:
    - `redirect_valid` & `imem_ack`: `pc`←`redirect_pc`; go to FETCH.
    - `redirect_valid` only: `pending_pc`←`redirect_pc` (latest redirect wins).
    - `imem_ack` only: `pc`←`pending_pc`; go to FETCH.
- `stallF` is ignored in DISCARD, and in FETCH without ack.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Throughput: one instruction per cycle when memory acks in zero wait states and there is no stall.
- Latency: `instrF` for address A is valid combinationally in the ack cycle. `if_id` captures it at that clock edge.
- A redirect asserted in cycle N:
  - with no request outstanding: the target is requested in cycle N+1;
  - with a request outstanding: the target is requested in the cycle after the stale ack.
- While `rst`=0:
  - `imem_req` is forced to 0;
  - `fetch_busy`=1;
  - `pcF`=`pc`; `instrF`=`imem_rdata`.
- First cycle after `rst` returns to 1: `imem_req`=1 and `imem_addr`=`RESET_PC`.
- Reset mid-request abandons the request. The instruction memory shares `rst` and discards it too.

## Structure
- Add to `defines.vh`:
  - `FETCH_STATE_WIDTH` (2);
  - state codes `FETCH_S_FETCH`=0, `FETCH_S_HOLD`=1, `FETCH_S_DISCARD`=2;
  - `PC_STEP` (32'd4).
- Reuse `WORD_WIDTH` and `ZERO_WORD`.
- Single module; no sub-module. Next-PC selection and the output multiplexing are in-module combinational logic.

## Test plan
- Reset with `RESET_PC`=32'h0000_3000 and zero-wait memory: `imem_addr` steps 3000, 3004, 3008 on consecutive cycles; `fetch_busy`=0 on each.
- Memory acks 3 cycles late: `fetch_busy`=1 for 3 cycles, then 0. `imem_addr` is held at 3000 throughout.
- `stallF` raised in the ack cycle of 3004 and held 2 cycles: `instrF`/`pcF` hold at 3004; `imem_req`=0; after release, 3008 is requested.
- Redirect to 32'h0000_4000 during a pending request at 3008: `imem_addr` stays 3008 until ack, then 4000 is requested; `fetch_busy`=1 throughout.
- Two redirects (5000, then 6000) while in DISCARD: the next request is 6000.
- `redirect_pc`=32'h0000_7002 with `pc` wrapping from FFFF_FFFC: the target is fetched at 7000, and FFFF_FFFC+4 is requested as 0000_0000.
